// File: rtl/switch_dev_pkg.sv
// Shared constants and helpers for the switch-port traffic endpoint:
// LFSR polynomial and seed, the address remap rule and the data-mode encodings.
package switch_dev_pkg;

    localparam int          LFSR_W    = 16;
    // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam int MODE_LFSR = 0;
    localparam int MODE_INCR = 1;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    // Folds a raw address in [NPORTS, 2^AW) back into the legal range.
    function automatic logic [31:0] remap_adr(input logic [31:0] raw, input int nports);
        return (raw >= 32'(nports)) ? raw - 32'(nports) : raw;
    endfunction

endpackage

// File: rtl/switch_dev_fifo.sv
// Synchronous FIFO with full/empty flags; a pop frees the slot for a
// same-cycle push, so push+pop while full is accepted.
module switch_dev_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        rdata_o  = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/switch_traffic_dev.sv
// Seedable traffic endpoint for one switch port: LFSR-driven TX generator
// behind a small FIFO, RX side with sticky grant and LFSR stall, plus counters.
module switch_traffic_dev
    import switch_dev_pkg::*;
#(
    parameter int          DW     = 4,
    parameter int          AW     = 3,
    parameter int          NPORTS = 5,
    parameter int          DEPTH  = 4,
    parameter int          MODE   = 0,
    parameter int          WRATE  = 128,
    parameter int          SRATE  = 64,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int          CW     = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          gen_en,
    output logic [AW-1:0] adr_i,
    output logic [DW-1:0] dat_i,
    output logic          validtx,
    input  logic          acktx,
    input  logic          validrx,
    input  logic [DW-1:0] dat_rx,
    output logic          ackrx,
    output logic [DW-1:0] rx_last,
    output logic [CW-1:0] tx_cnt,
    output logic [CW-1:0] rx_cnt,
    output logic [CW-1:0] drop_cnt
);

    localparam int            FW      = AW + DW;
    localparam logic [8:0]    WRATE_9 = 9'(WRATE);
    localparam logic [8:0]    SRATE_9 = 9'(SRATE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [DW-1:0] DAT_ONE = DW'(1);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DW-1:0]     seq_q, seq_d;
    logic              validtx_q, validtx_d;
    logic              ackrx_q, ackrx_d;
    logic [DW-1:0]     rx_last_q, rx_last_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

    logic              gen, stall, pop, push, drop, rx_take;
    logic              fifo_full, fifo_empty;
    logic [AW-1:0]     gen_adr;
    logic [DW-1:0]     gen_dat;
    logic [FW-1:0]     fifo_wdata, fifo_rdata;

    always_comb begin
        gen     = gen_en & ({1'b0, lfsr_q[7:0]} < WRATE_9);
        stall   = {1'b0, lfsr_q[15:8]} < SRATE_9;
        pop     = validtx_q & acktx;
        push    = gen & (~fifo_full | pop);
        drop    = gen & fifo_full & ~pop;
        rx_take = validrx & ackrx_q;

        gen_adr = AW'(remap_adr(32'(lfsr_q[AW-1:0]), NPORTS));
        // Top DW bits of the LFSR, replicated when DW exceeds 16
        gen_dat = (MODE == MODE_INCR) ? seq_q
                                      : DW'({lfsr_q, lfsr_q} >> (32 - DW));
        fifo_wdata = {gen_adr, gen_dat};

        lfsr_d     = lfsr_step(lfsr_q);
        seq_d      = push ? seq_q + DAT_ONE : seq_q;
        // A transfer always forces one idle bubble before the next word
        validtx_d  = ~pop & ~fifo_empty;
        ackrx_d    = ackrx_q ? validrx : (validrx & ~stall);
        rx_last_d  = rx_take ? dat_rx : rx_last_q;
        tx_cnt_d   = pop     ? tx_cnt_q + CNT_ONE   : tx_cnt_q;
        rx_cnt_d   = rx_take ? rx_cnt_q + CNT_ONE   : rx_cnt_q;
        drop_cnt_d = drop    ? drop_cnt_q + CNT_ONE : drop_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lfsr_q     <= SEED;
            seq_q      <= '0;
            validtx_q  <= 1'b0;
            ackrx_q    <= 1'b0;
            rx_last_q  <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            seq_q      <= seq_d;
            validtx_q  <= validtx_d;
            ackrx_q    <= ackrx_d;
            rx_last_q  <= rx_last_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    switch_dev_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign adr_i    = fifo_rdata[FW-1 -: AW];
    assign dat_i    = fifo_rdata[DW-1:0];
    assign validtx  = validtx_q;
    assign ackrx    = ackrx_q;
    assign rx_last  = rx_last_q;
    assign tx_cnt   = tx_cnt_q;
    assign rx_cnt   = rx_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_switch_traffic_dev.sv
// Bench for switch_traffic_dev: random traffic on a default instance against a
// queue-based reference model, then directed scenarios on tuned instances.
module tb_switch_traffic_dev;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // instance 0: default parameters, random traffic
    logic        rst0 = 1'b0, gen0 = 1'b0, ack0 = 1'b0, vrx0 = 1'b0;
    logic [3:0]  drx0 = '0;
    logic [2:0]  adr0;
    logic [3:0]  dat0, rxl0;
    logic        vtx0, ackrx0;
    logic [15:0] tx0, rx0, drop0;

    // instances 1 and 2 share stimulus
    logic        rst1 = 1'b0, g1 = 1'b0, a1 = 1'b0, v1 = 1'b0;
    logic [3:0]  d1 = '0;
    logic [2:0]  adr1, adr2;
    logic [3:0]  dat1, rxl1, dat2, rxl2;
    logic        vtx1, ackrx1, vtx2, ackrx2;
    logic [15:0] tx1, rx1, drop1, tx2, rx2, drop2;

    switch_traffic_dev dut0 (
        .clk_i(clk), .rst_i(rst0), .gen_en(gen0), .adr_i(adr0), .dat_i(dat0),
        .validtx(vtx0), .acktx(ack0), .validrx(vrx0), .dat_rx(drx0), .ackrx(ackrx0),
        .rx_last(rxl0), .tx_cnt(tx0), .rx_cnt(rx0), .drop_cnt(drop0));

    switch_traffic_dev #(.MODE(1), .WRATE(256), .SRATE(0)) dut1 (
        .clk_i(clk), .rst_i(rst1), .gen_en(g1), .adr_i(adr1), .dat_i(dat1),
        .validtx(vtx1), .acktx(a1), .validrx(v1), .dat_rx(d1), .ackrx(ackrx1),
        .rx_last(rxl1), .tx_cnt(tx1), .rx_cnt(rx1), .drop_cnt(drop1));

    switch_traffic_dev #(.WRATE(0), .SRATE(256)) dut2 (
        .clk_i(clk), .rst_i(rst1), .gen_en(g1), .adr_i(adr2), .dat_i(dat2),
        .validtx(vtx2), .acktx(a1), .validrx(v1), .dat_rx(d1), .ackrx(ackrx2),
        .rx_last(rxl2), .tx_cnt(tx2), .rx_cnt(rx2), .drop_cnt(drop2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model for instance 0: state after the most recent clock edge
    int unsigned m_lfsr;
    int          m_q[$];
    bit          m_vtx, m_ack;
    int          m_rxl, m_tx, m_rx, m_drop;

    task automatic model_step(input bit r, input bit g, input bit a, input bit v, input int d);
        int  sz_pre, raw, adr, dat;
        bit  xfer, want, stall;
        if (!r) begin
            m_lfsr = 'hACE1;
            m_q.delete();
            m_vtx = 0; m_ack = 0;
            m_rxl = 0; m_tx = 0; m_rx = 0; m_drop = 0;
        end else begin
            sz_pre = m_q.size();
            xfer   = m_vtx && a;
            want   = g && ((m_lfsr % 256) < 128);
            stall  = ((m_lfsr / 256) % 256) < 64;
            raw    = m_lfsr % 8;
            adr    = (raw >= 5) ? raw - 5 : raw;
            dat    = (m_lfsr / 4096) % 16;
            if (xfer) begin
                void'(m_q.pop_front());
                m_tx = (m_tx + 1) % 65536;
            end
            if (want) begin
                if (m_q.size() < 4) m_q.push_back(adr * 16 + dat);
                else m_drop = (m_drop + 1) % 65536;
            end
            m_vtx = !xfer && (sz_pre > 0);
            if (v && m_ack) begin
                m_rxl = d;
                m_rx  = (m_rx + 1) % 65536;
            end
            m_ack = m_ack ? v : (v && !stall);
            m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
        end
    endtask

    task automatic chk_dut2_idle(input string tag);
        chk(tag, {vtx2, ackrx2, tx2, rx2, drop2, rxl2, adr2, dat2}, 32'h0);
    endtask

    initial begin
        int exp_dat;
        logic [3:0] rd [7];

        // ---------------- random traffic on instance 0 ----------------
        model_step(0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("vtx", vtx0, 32'(m_vtx));
            chk("ackrx", ackrx0, 32'(m_ack));
            chk("tx_cnt", tx0, 32'(m_tx));
            chk("rx_cnt", rx0, 32'(m_rx));
            chk("drop_cnt", drop0, 32'(m_drop));
            chk("rx_last", rxl0, 32'(m_rxl));
            chk("adr_range", 32'(adr0 < 3'd5), 32'h1);
            if (m_vtx) begin
                chk("head_adr", adr0, 32'(m_q[0] / 16));
                chk("head_dat", dat0, 32'(m_q[0] % 16));
            end
            rst0 = (c < 3) ? 1'b0 : ($urandom_range(0, 249) != 0);
            gen0 = ($urandom_range(0, 3) != 0);
            ack0 = $urandom_range(0, 1) != 0;
            vrx0 = ($urandom_range(0, 9) < 6);
            drx0 = 4'($urandom);
            model_step(rst0, gen0, ack0, vrx0, int'(drx0));
        end
        rst0 = 1'b0;

        // ---------------- reset behaviour (instance 1) ----------------
        rst1 = 0; g1 = 1; a1 = 0; v1 = 1; d1 = 4'h5;
        repeat (3) begin
            @(negedge clk);
            chk("rst_vtx", vtx1, 32'h0);
            chk("rst_ackrx", ackrx1, 32'h0);
            chk("rst_cnts", {tx1, rx1}, 32'h0);
            chk("rst_drop", drop1, 32'h0);
            chk_dut2_idle("rst_dut2");
        end

        // ---------------- MODE 1 ordering, acktx tied high ----------------
        rst1 = 1; v1 = 0; a1 = 1;
        @(negedge clk);
        chk("first_vtx_cycle1", vtx1, 32'h0);
        exp_dat = 0;
        for (int c = 2; c <= 21; c++) begin
            @(negedge clk);
            chk("m1_alternate", vtx1, 32'((c % 2) == 0));
            if ((c % 2) == 0) begin
                chk("m1_order", dat1, 32'(exp_dat));
                exp_dat++;
            end
        end
        chk("m1_tx_cnt", tx1, 32'd10);

        // ---------------- full FIFO then drain ----------------
        rst1 = 0; a1 = 0; g1 = 1;
        repeat (2) @(negedge clk);
        rst1 = 1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            chk("full_drop", drop1, 32'((e > 4) ? e - 4 : 0));
            if (e >= 2) begin
                chk("full_vtx", vtx1, 32'h1);
                chk("full_head", dat1, 32'h0);
            end
        end
        g1 = 0; a1 = 1;
        exp_dat = 1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (vtx1) begin
                chk("drain_order", dat1, 32'(exp_dat));
                exp_dat++;
            end
        end
        chk("drain_words", 32'(exp_dat), 32'd4);
        chk("drain_tx_cnt", tx1, 32'd4);
        chk("drain_drop_hold", drop1, 32'd6);
        chk("drain_idle", vtx1, 32'h0);

        // ---------------- reset mid-operation ----------------
        rst1 = 0;
        @(negedge clk);
        rst1 = 1; a1 = 0; g1 = 1;
        repeat (3) @(negedge clk);
        chk("mid_vtx_before", vtx1, 32'h1);
        rst1 = 0; g1 = 0; a1 = 1;
        @(negedge clk);
        chk("mid_vtx", vtx1, 32'h0);
        chk("mid_tx_cnt", tx1, 32'h0);
        chk("mid_head", {adr1, dat1}, 32'h0);
        rst1 = 1;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            chk("mid_empty", vtx1, 32'h0);
        end
        g1 = 1;
        @(negedge clk);
        g1 = 0;
        chk("mid_lat1", vtx1, 32'h0);
        @(negedge clk);
        chk("mid_lat2", vtx1, 32'h1);
        chk("mid_seq_restart", dat1, 32'h0);

        // ---------------- RX sticky grant ----------------
        rst1 = 0; a1 = 0; g1 = 0; v1 = 0;
        @(negedge clk);
        rst1 = 1;
        for (int e = 1; e <= 6; e++) begin
            rd[e] = 4'($urandom);
            v1 = 1; d1 = rd[e];
            @(negedge clk);
            chk("rx_ack_high", ackrx1, 32'h1);
            chk_dut2_idle("rx_dut2_stalled");
        end
        v1 = 0; d1 = ~rd[6];
        @(negedge clk);
        chk("rx_ack_drop", ackrx1, 32'h0);
        chk("rx_cnt5", rx1, 32'd5);
        chk("rx_last6", rxl1, 32'(rd[6]));
        chk_dut2_idle("rx_dut2_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
